brc_iter: RTL
=============

// Module: brc_iter
// PURPOSE
//  Parametrised multi-cycle branch comparator for the RV32I core and its
//  low-area variants. Accepts two operands plus a RISC-V branch funct3 over a
//  valid/ready handshake, compares CHUNK bits per cycle MSB-first with early
//  exit, and returns less/equal/taken flags over a second valid/ready port.
// PARAMETERS
//  WIDTH  32  operand width in bits; must be a multiple of CHUNK
//  CHUNK  8   bits compared per cycle; CHUNK==WIDTH gives a fixed 2-cycle unit
//  NCH    WIDTH/CHUNK (localparam)  chunk count; IDXW = max(1,$clog2(NCH))
// PORTS
//  i_clk       in   1      clock, rising edge
//  i_rst       in   1      asynchronous reset, active-high
//  i_flush     in   1      synchronous abort of any in-flight compare
//  i_valid     in   1      request valid
//  o_ready     out  1      unit can accept a request
//  i_rs1_data  in   WIDTH  operand A
//  i_rs2_data  in   WIDTH  operand B
//  i_br_op     in   3      funct3: 000 BEQ, 001 BNE, 100 BLT, 101 BGE, 110 BLTU, 111 BGEU
//  o_valid     out  1      result valid
//  i_ready     in   1      consumer accepts result
//  o_br_less   out  1      A < B (signed for 10x ops, unsigned for 11x ops)
//  o_br_equal  out  1      A == B
//  o_taken     out  1      branch condition true for i_br_op
//  o_illegal   out  1      i_br_op was 010 or 011
// BEHAVIOUR
//  Reset: state IDLE; o_ready=1; o_valid, o_br_less, o_br_equal, o_taken,
//   o_illegal = 0; operand and index registers = 0.
//  FSM IDLE -> CMP -> DONE -> IDLE.
//  IDLE: o_ready=1. Accept on i_valid & o_ready & ~i_flush. Latch operands and
//   op, set idx=NCH-1, go to CMP. For signed ops (op[2:1]==2'b10), invert bit
//   WIDTH-1 of both latched operands so an unsigned compare gives the signed order.
//   For BEQ/BNE/illegal ops the operands are latched unmodified.
//  CMP: compare chunk idx of A against chunk idx of B, unsigned.
//   If the chunks differ: less = (A_chunk < B_chunk), equal = 0, go to DONE.
//   Else if idx==0: less = 0, equal = 1, go to DONE. Else idx <= idx-1, stay in CMP.
//  DONE: o_valid=1. Outputs are stable until handshake. On i_ready, go to IDLE
//   with o_valid=0 on the next cycle. A new request cannot be accepted in the
//   same cycle as the result handshake.
//  Latency from accept edge to o_valid=1: k+1 cycles, where k (1..NCH) is the
//   number of CMP cycles. Equal operands always take NCH+1 cycles.
//  o_taken:
//   BEQ = equal; BNE = ~equal.
//   BLT/BLTU = less; BGE/BGEU = ~less.
//   Illegal op: o_taken=0 and o_illegal=1; less/equal are still computed unsigned.
//  o_ready=0 in CMP and DONE.
//  i_flush (any state): next state IDLE; o_valid, o_taken, o_illegal cleared.
//   i_flush takes priority over a simultaneous i_valid, which is not accepted,
//   and over a simultaneous i_ready.
//  Async reset mid-compare: immediate return to IDLE with reset values.
//   The partial result is discarded.
//  Operands may change after accept without affecting the result.
// TESTING
//  BLTU A=0x0000_0001 B=0xFFFF_FFFF -> result after 2 cycles (top chunk differs),
//   less=1, equal=0, taken=1.
//  BLT A=0x8000_0000 B=0x0000_0001 -> less=1, taken=1.
//  BGE A=0x8000_0000 B=0x0000_0001 -> less=1, taken=0.
//  BEQ A=B=0x1234_5678 -> o_valid exactly 5 cycles after accept, equal=1, taken=1.
//   Also run with CHUNK=32: 2 cycles.
//  BNE A=0x1234_5678 B=0x1234_5679 -> decided at last chunk, latency 5, taken=1.
//   Hold i_ready=0 for 3 cycles: outputs stable, o_ready=0 throughout.
//  Assert i_flush in the 2nd CMP cycle of an equal compare -> IDLE next cycle,
//   o_valid never pulses. Assert i_flush with i_valid in IDLE -> request dropped.
//  Assert i_rst mid-compare -> all outputs 0 and o_ready=1 immediately.
//  Issue op=3'b010 -> o_illegal=1, taken=0.
//  Randomized: 10k ops at WIDTH=32/CHUNK=8 and WIDTH=64/CHUNK=16, each
//   checked against a $signed/$unsigned reference model.

Source files
------------

// File: rtl/brc_iter_if.sv
// Request/response bundle for the iterative branch comparator.
// The master side issues operands and consumes flags; the slave side is the unit.
interface brc_iter_if #(
    parameter int WIDTH = 32
);
    logic             i_flush;
    logic             i_valid;
    logic             o_ready;
    logic [WIDTH-1:0] i_rs1_data;
    logic [WIDTH-1:0] i_rs2_data;
    logic [2:0]       i_br_op;
    logic             o_valid;
    logic             i_ready;
    logic             o_br_less;
    logic             o_br_equal;
    logic             o_taken;
    logic             o_illegal;

    modport master (
        output i_flush, i_valid, i_rs1_data, i_rs2_data, i_br_op, i_ready,
        input  o_ready, o_valid, o_br_less, o_br_equal, o_taken, o_illegal
    );

    modport slave (
        input  i_flush, i_valid, i_rs1_data, i_rs2_data, i_br_op, i_ready,
        output o_ready, o_valid, o_br_less, o_br_equal, o_taken, o_illegal
    );
endinterface

// File: rtl/brc_iter.sv
// Multi-cycle RISC-V branch comparator: CHUNK bits per cycle, MSB-first with
// early exit on the first differing chunk; result held until handshake.
module brc_iter #(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8
) (
    input  logic       i_clk,
    input  logic       i_rst,
    brc_iter_if.slave  bus
);
    localparam int NCH  = WIDTH / CHUNK;
    localparam int IDXW = (NCH > 1) ? $clog2(NCH) : 1;

    typedef enum logic [1:0] {IDLE, CMP, DONE} state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] a_q, b_q;
    logic [2:0]       op_q;
    logic [IDXW-1:0]  idx_q;
    logic             less_q, equal_q, taken_q, illegal_q, valid_q;
    logic             accept, decided;
    logic [CHUNK-1:0] a_chunk, b_chunk;
    logic             chunk_ne, chunk_lt;
    logic             taken_nxt, illegal_nxt;
    logic [WIDTH-1:0] flip;

    // Flipping the sign bit of both operands maps signed order onto unsigned order.
    assign flip = {(bus.i_br_op[2:1] == 2'b10), {(WIDTH-1){1'b0}}};

    assign a_chunk  = a_q[idx_q*CHUNK +: CHUNK];
    assign b_chunk  = b_q[idx_q*CHUNK +: CHUNK];
    assign chunk_ne = (a_chunk != b_chunk);
    assign chunk_lt = (a_chunk < b_chunk);

    always_comb begin
        illegal_nxt = (op_q[2:1] == 2'b01);
        case (op_q)
            3'b000:         taken_nxt = ~chunk_ne;
            3'b001:         taken_nxt = chunk_ne;
            3'b100, 3'b110: taken_nxt = chunk_lt;
            3'b101, 3'b111: taken_nxt = ~chunk_lt;
            default:        taken_nxt = 1'b0;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        decided   = 1'b0;
        case (state)
            IDLE: if (bus.i_valid && !bus.i_flush) begin
                accept    = 1'b1;
                state_nxt = CMP;
            end
            CMP: if (chunk_ne || idx_q == '0) begin
                decided   = 1'b1;
                state_nxt = DONE;
            end
            DONE: if (valid_q && bus.i_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        if (bus.i_flush) state_nxt = IDLE;
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            a_q       <= '0;
            b_q       <= '0;
            op_q      <= '0;
            idx_q     <= '0;
            less_q    <= 1'b0;
            equal_q   <= 1'b0;
            taken_q   <= 1'b0;
            illegal_q <= 1'b0;
            valid_q   <= 1'b0;
        end else begin
            if (accept) begin
                a_q   <= bus.i_rs1_data ^ flip;
                b_q   <= bus.i_rs2_data ^ flip;
                op_q  <= bus.i_br_op;
                idx_q <= IDXW'(NCH - 1);
            end else if (state == CMP && !decided) begin
                idx_q <= idx_q - 1'b1;
            end
            if (decided) begin
                less_q    <= chunk_ne & chunk_lt;
                equal_q   <= ~chunk_ne;
                taken_q   <= taken_nxt;
                illegal_q <= illegal_nxt;
            end
            // o_valid rises one cycle after entering DONE and drops after the handshake.
            if (bus.i_flush) begin
                valid_q   <= 1'b0;
                taken_q   <= 1'b0;
                illegal_q <= 1'b0;
            end else if (state == DONE) begin
                valid_q <= valid_q ? !bus.i_ready : 1'b1;
            end
        end
    end

    assign bus.o_ready    = (state == IDLE);
    assign bus.o_valid    = valid_q;
    assign bus.o_br_less  = less_q;
    assign bus.o_br_equal = equal_q;
    assign bus.o_taken    = taken_q;
    assign bus.o_illegal  = illegal_q;
endmodule
